// File: rtl/req_gnt_arbiter_pkg.sv
// Shared types and width helpers for the round-robin req/gnt arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Width of a requester index; a single-bit index is kept even for tiny N.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a hold counter that must be able to reach max_hold.
    function automatic int cnt_w(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/req_gnt_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until granted; the arbiter answers on gnt.
interface req_gnt_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = arb_pkg::idx_w(N);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          timeout;

    // Requester side: raises requests, observes grants.
    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    // Arbiter side: observes requests, drives grants.
    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );

endinterface

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or above ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // One extra bit so ptr + offset never overflows before the wrap subtract.
    logic [IW:0] cand;

    // Walk N candidates starting at ptr; once found, later bits are masked out
    // so unknown request bits past the winner cannot disturb the result.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin arbiter granting one of N requesters, hold bounded by MAX_HOLD.
// Latency: 1 cycle req->gnt from idle; one forced gnt=0 turnaround between owners.
// Backpressure: non-owners wait while the owner holds req; no preemption.
module req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    req_gnt_arbiter_if.slave bus
);

    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(MAX_HOLD);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          hold_done;
    logic [IW-1:0] next_ptr;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Only the current owner's request bit is ever looked at during a grant.
    assign owner_req = bus.req[gnt_id_q];
    assign hold_done = (hold_cnt_q == HOLD_MAX);
    assign next_ptr  = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + IW'(1);

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next state, round-robin pointer and hold counter.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE, RELEASE: begin
                // RELEASE is the turnaround cycle; it also arbitrates so the
                // next owner sees gnt the cycle right after it.
                if (pick_found) begin
                    state_d    = GRANT;
                    hold_cnt_d = CW'(1);
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req || hold_done) begin
                    // Pointer moves past the owner so a timed-out requester
                    // lines up behind everyone else still asking.
                    state_d    = RELEASE;
                    rr_ptr_d   = next_ptr;
                    hold_cnt_d = '0;
                end else begin
                    // hold_done is false here, so the counter stops at MAX_HOLD.
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs for the next cycle: new grant, kept grant or revoke.
    always_comb begin
        gnt_d     = '0;
        gnt_id_d  = '0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    gnt_id_d        = pick_idx;
                end
            end
            GRANT: begin
                if (owner_req && !hold_done) begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
                end else if (owner_req) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Scoreboard bench for req_gnt_arbiter: directed grant sequences plus random traffic.
// Latency: expects gnt one cycle after req from idle, one zero cycle between owners.
// Backpressure: requesters keep req high until granted.
module tb_req_gnt_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int BOUND    = (N - 1) * (MAX_HOLD + 1) + 1;
    localparam int EV_GRANT = 0;
    localparam int EV_TMO   = 1;

    typedef struct {
        int kind;
        int id;
        int len;
        int gap;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    req_gnt_arbiter_if #(.N(N)) bus ();

    req_gnt_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   sb_en  = 1'b0;
    ev_t  sb[$];

    logic [N-1:0] prev_gnt;
    logic [N-1:0] oh;
    int           run_len;
    int           run_id;
    int           run_gap;
    int           zero_run;
    int           wait_cnt[N];
    bit           starved[N];

    logic [N-1:0] r;
    int           hold[N];
    bit           dpend[N];
    int           starts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int kind, input int id, input int len, input int gap);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.len  = len;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int id, input int len, input int gap);
        ev_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d id %0d len %0d, expected none", kind, id, len);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == EV_GRANT && kind == EV_GRANT) begin
                chk("grant_owner", id, e.id);
                chk("grant_len", len, e.len);
                if (e.gap >= 0) chk("grant_gap", gap, e.gap);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        bus.req = '0;
        tick(2);
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_gnt_valid", bus.gnt_valid, 0);
        chk("reset_gnt_id", bus.gnt_id, 0);
        chk("reset_timeout", bus.timeout, 0);
        reset = 1'b0;
    endtask

    // Monitor: protocol invariants every cycle, grant/timeout events to the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_gnt = '0;
            run_len  = 0;
            run_id   = 0;
            run_gap  = 0;
            zero_run = 0;
            for (int i = 0; i < N; i++) begin
                wait_cnt[i] = 0;
                starved[i]  = 1'b0;
            end
        end else begin
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
            chk("gnt_valid_or", bus.gnt_valid, 32'(|bus.gnt));
            if (bus.gnt != '0) begin
                oh = '0;
                oh[bus.gnt_id] = 1'b1;
                chk("gnt_id_match", bus.gnt, oh);
                if (prev_gnt != '0) chk("owner_change_gap", bus.gnt, prev_gnt);
                if (prev_gnt == '0) begin
                    run_len = 1;
                    run_gap = zero_run;
                end else begin
                    run_len++;
                end
                run_id = int'(bus.gnt_id);
                chk("hold_bound", 32'(run_len <= MAX_HOLD), 1);
                zero_run = 0;
            end else begin
                chk("gnt_id_idle", bus.gnt_id, 0);
                if (prev_gnt != '0 && sb_en) pop_cmp(EV_GRANT, run_id, run_len, run_gap);
                zero_run++;
            end
            if (bus.timeout) begin
                chk("timeout_gnt_zero", bus.gnt, 0);
                chk("timeout_after_grant", 32'(prev_gnt != '0), 1);
                chk("timeout_len", run_len, MAX_HOLD);
                if (sb_en) pop_cmp(EV_TMO, 0, 0, 0);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !bus.gnt[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > BOUND && !starved[i]) begin
                        starved[i] = 1'b1;
                        n_chk++;
                        $display("FAIL starvation: requester %0d waited %0d cycles, bound %0d", i, wait_cnt[i], BOUND);
                    end
                end else begin
                    if (bus.gnt[i] && wait_cnt[i] > 0) begin
                        n_chk++;
                        if (wait_cnt[i] <= BOUND) n_pass++;
                        else $display("FAIL fairness_wait: requester %0d waited %0d cycles, bound %0d", i, wait_cnt[i], BOUND);
                    end
                    wait_cnt[i] = 0;
                    starved[i]  = 1'b0;
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        bus.req = '0;

        // Single requester: five grant cycles, no timeout.
        apply_reset();
        sb_en = 1'b1;
        push(EV_GRANT, 0, 5, -1);
        bus.req = 4'b0001;
        tick(5);
        bus.req = 4'b0000;
        tick(4);
        chk("t1_sb_drained", sb.size(), 0);
        chk("t1_idle_gnt", bus.gnt, 0);

        // Round robin: all request, each owner drops after 3 cycles, re-raises next cycle.
        apply_reset();
        push(EV_GRANT, 0, 3, -1);
        push(EV_GRANT, 1, 3, 1);
        push(EV_GRANT, 2, 3, 1);
        push(EV_GRANT, 3, 3, 1);
        push(EV_GRANT, 0, 3, 1);
        for (int i = 0; i < N; i++) begin
            hold[i]  = 0;
            dpend[i] = 1'b0;
        end
        starts  = 0;
        r       = 4'b1111;
        bus.req = r;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            for (int i = 0; i < N; i++) begin
                if (dpend[i]) begin
                    if (starts < 5) r[i] = 1'b1;
                    dpend[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) begin
                    if (hold[i] == 0) begin
                        starts++;
                        if (starts == 5) r = r & bus.gnt;
                    end
                    hold[i]++;
                    if (hold[i] == 3) begin
                        r[i]     = 1'b0;
                        dpend[i] = 1'b1;
                        hold[i]  = 0;
                    end
                end
            end
            bus.req = r;
        end
        bus.req = '0;
        tick(3);
        chk("t2_sb_drained", sb.size(), 0);

        // Timeout: sole requester holds 16 cycles, revoked, re-granted after one zero cycle.
        apply_reset();
        push(EV_GRANT, 1, MAX_HOLD, -1);
        push(EV_TMO, 0, 0, 0);
        push(EV_GRANT, 1, 2, 1);
        bus.req = 4'b0010;
        tick(19);
        bus.req = 4'b0000;
        tick(4);
        chk("t3_sb_drained", sb.size(), 0);

        // Timeout fairness: requester 0 keeps asking, 1 is served before 0 again.
        apply_reset();
        push(EV_GRANT, 0, MAX_HOLD, -1);
        push(EV_TMO, 0, 0, 0);
        push(EV_GRANT, 1, 2, 1);
        push(EV_GRANT, 0, 3, 1);
        bus.req = 4'b0011;
        tick(19);
        bus.req = 4'b0001;
        tick(4);
        bus.req = 4'b0000;
        tick(4);
        chk("t4_sb_drained", sb.size(), 0);

        // Reset mid-grant clears outputs at once; restart from pointer 0.
        apply_reset();
        bus.req = 4'b0100;
        tick(3);
        #2;
        chk("t5_pre_reset_gnt", bus.gnt, 4'b0100);
        reset = 1'b1;
        #1;
        chk("t5_async_gnt", bus.gnt, 0);
        chk("t5_async_gnt_valid", bus.gnt_valid, 0);
        chk("t5_async_timeout", bus.timeout, 0);
        chk("t5_async_gnt_id", bus.gnt_id, 0);
        @(posedge clk);
        #1;
        push(EV_GRANT, 2, 2, -1);
        bus.req = 4'b1100;
        reset   = 1'b0;
        tick(2);
        bus.req = 4'b0000;
        tick(4);
        chk("t5_sb_drained", sb.size(), 0);

        // Random traffic: requests stay up until granted; owners drop at random.
        apply_reset();
        sb_en = 1'b0;
        r     = '0;
        for (int c = 0; c < 2000; c++) begin
            tick(1);
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) begin
                    if ($urandom_range(0, (i == 0) ? 7 : 3) == 0) r[i] = 1'b0;
                end else if (!r[i]) begin
                    if ($urandom_range(0, 2) == 0) r[i] = 1'b1;
                end
            end
            bus.req = r;
        end
        bus.req = '0;
        tick(MAX_HOLD + 4);
        chk("t6_idle_gnt", bus.gnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/req_gnt_arbiter.md
Name: req_gnt_arbiter

Overview:
- Round-robin arbiter that shares one req/gnt-guarded resource among N requesters.
- Grants exactly one requester at a time, one-hot `gnt`.
- Holds the grant while the owner keeps `req` asserted, bounded by a hold limit.
- Sits in front of the shared resource; its `req`/`gnt` protocol is what our multi-clock req→gnt assertions check downstream.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold `gnt` (≥1).

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request per requester, level-sensitive.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  $clog2(N) (min 1)  registered index of current owner; 0 when idle.
- timeout  output  1  one-cycle registered pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous, immediate):
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0.
  - state=IDLE, rr_ptr=0, hold_cnt=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req≠0, pick the winner by round-robin starting at rr_ptr, searching upward with wrap.
  - Next cycle: gnt=onehot(winner), gnt_id=winner, hold_cnt=1, state=GRANT.
  - Latency is 1 cycle from req sampled high to gnt high.
  - If req==0, stay in IDLE.
- GRANT, owner's req dropped (sampled low):
  - Next cycle gnt=0, state=RELEASE, rr_ptr=(owner+1) mod N.
- GRANT, owner's req high and hold_cnt==MAX_HOLD:
  - Next cycle gnt=0, timeout=1 for one cycle, state=RELEASE, rr_ptr=(owner+1) mod N.
- GRANT, otherwise:
  - Keep the grant; hold_cnt increments.
  - Requests from non-owners are ignored; no preemption.
- RELEASE:
  - Exactly one cycle with gnt=0, the mandatory bus turnaround.
  - Then arbitrate as in IDLE in the same evaluation: if req≠0, the grant appears the cycle after RELEASE; else go to IDLE.
- gnt is never asserted for two consecutive owners without a zero cycle between them.
- Fairness: a continuously requesting requester waits at most (N-1)·(MAX_HOLD+1) cycles plus 1 for a grant.
- Timed-out owner that keeps req high is re-granted only after all other active requesters are served. If it is the sole requester, it is re-granted after the RELEASE cycle.
- hold_cnt width: $clog2(MAX_HOLD+1); it saturates and never wraps.
- rr_ptr wraps from N-1 to 0.
- Requester bits ≥N do not exist; no X propagation onto gnt from unknown req bits of non-winners.
- Reset asserted mid-grant clears gnt in the same instant. After deassertion, arbitration restarts from requester 0 priority.

Decomposition:
- Package arb_pkg: typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t; localparam functions for index width.
- Sub-module rr_pick: purely combinational round-robin priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: found, idx.
  - Instantiated once; the FSM, counters and output registers stay in req_gnt_arbiter.

Test Plan:
- Single requester: after reset, req=4'b0001 held 5 cycles then dropped → gnt=0001 from cycle 2 to cycle 6, then one RELEASE cycle with gnt=0, then IDLE; timeout never asserts.
- Round-robin: req=4'b1111 held, each owner drops req after 3 grant cycles and re-raises 1 cycle later → grant order 0,1,2,3,0 with exactly one gnt=0 cycle between owners.
- Timeout: MAX_HOLD=16, req=4'b0010 held constantly → gnt[1] high exactly 16 cycles, then timeout=1 for one cycle with gnt=0, then gnt[1] re-granted.
- Timeout fairness: req=4'b0011, requester 0 never drops → after 16 cycles timeout, grant passes to 1 before 0 is served again.
- Reset mid-grant: assert reset asynchronously (between clock edges) while gnt=0100 → gnt, gnt_valid, timeout go 0 immediately. After release, with req=4'b1100, the first grant goes to requester 2, since pointer 0 searches upward.
- Protocol check: random req for 2000 cycles → gnt always one-hot or zero; gnt_valid==|gnt; no back-to-back owner change without a zero cycle; no starvation beyond the fairness bound.
